vga_timing_pattern_gen: RTL

//  Parametrised VGA timing and test-pattern generator; next generation of vga_main.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_key_debounce.sv | 45 ++++
 rtl/vga_timing_pattern_gen.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, pattern-mode encoding and the colour-bar table
// for the VGA timing and test-pattern generator.
package vga_pkg;

    localparam int DEF_H_ACTIVE        = 640;
    localparam int DEF_H_FP            = 16;
    localparam int DEF_H_SYNC          = 96;
    localparam int DEF_H_BP            = 48;
    localparam int DEF_V_ACTIVE        = 480;
    localparam int DEF_V_FP            = 10;
    localparam int DEF_V_SYNC          = 2;
    localparam int DEF_V_BP            = 33;
    localparam int DEF_CLK_DIV         = 2;
    localparam int DEF_COLOR_W         = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_GRID  = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_SOLID = 2'd3
    } mode_t;

    // One bit per channel; each bit is later widened to full scale or zero.
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb1_t;

    localparam logic [2:0] BAR_TABLE [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic rgb1_t bar_colour(input logic [2:0] idx);
        return rgb1_t'(BAR_TABLE[idx]);
    endfunction

endpackage

// File: rtl/vga_key_debounce.sv
// Active-low push-button conditioner: two-flop synchroniser, stability counter,
// and a one-cycle pulse on each accepted press (falling edge).
module vga_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_key_n,
    output logic o_press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             w_key;

    // NOTE: KEY is asynchronous to the clock, so nothing may look at it before the second flop.
    assign w_key = r_sync[1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync   <= 2'b11;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            if (w_key == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt    <= '0;
                r_stable <= w_key;
                r_press  <= r_stable & ~w_key;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// VGA timing generator with four selectable test patterns; all video outputs are
// registered on the pixel clock-enable so sync, blank, colour and coordinates stay aligned.
module vga_timing_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter bit HS_POL          = 1'b0,
    parameter bit VS_POL          = 1'b0,
    parameter int CLK_DIV         = DEF_CLK_DIV,
    parameter int COLOR_W         = DEF_COLOR_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic               CLOCK_50M,
    input  logic               reset,
    input  logic [2:0]         KEY,
    output logic               hs,
    output logic               vs,
    output logic               VGA_BLANK,
    output logic               VGA_CLK,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic [10:0]        pix_x,
    output logic [9:0]         pix_y,
    output logic               frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BAR_CW  = $clog2(BAR_W + 1);

    logic [DIV_W-1:0]  r_div_cnt;
    logic [DIV_W-1:0]  w_div_next;
    logic              w_pix_ce;
    logic [H_W-1:0]    r_h_cnt;
    logic [V_W-1:0]    r_v_cnt;
    logic              w_h_last;
    logic              w_v_last;
    logic [BAR_CW-1:0] r_bar_px;
    logic [2:0]        r_bar_idx;
    int                w_h;
    int                w_v;
    logic              w_active;
    logic              w_h_sync;
    logic              w_v_sync;
    logic              w_origin;
    logic              w_commit;
    logic [10:0]       w_x;
    logic [9:0]        w_y;
    logic [2:0]        w_req;
    logic [2:0]        r_pend;
    mode_t             r_mode;
    logic [2:0]        r_idx;
    logic              r_inv;
    mode_t             w_mode_eff;
    logic [2:0]        w_idx_eff;
    logic              w_inv_eff;
    rgb1_t             w_bar;
    rgb1_t             w_solid;
    logic              w_grid_on;
    logic [COLOR_W-1:0] w_r, w_g, w_b;

    logic               r_hs, r_vs, r_blank, r_vga_clk, r_frame_start;
    logic [COLOR_W-1:0] r_r, r_g, r_b;
    logic [10:0]        r_pix_x;
    logic [9:0]         r_pix_y;

    assign w_pix_ce   = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_div_next = w_pix_ce ? '0 : r_div_cnt + DIV_W'(1);
    assign w_h_last   = (r_h_cnt == H_W'(H_TOTAL - 1));
    assign w_v_last   = (r_v_cnt == V_W'(V_TOTAL - 1));

    always_ff @(posedge CLOCK_50M) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_vga_clk <= 1'b0;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else begin
            r_div_cnt <= w_div_next;
            r_vga_clk <= (w_div_next >= DIV_W'(CLK_DIV / 2));
            if (w_pix_ce) begin
                if (w_h_last) begin
                    r_h_cnt   <= '0;
                    r_v_cnt   <= w_v_last ? '0 : r_v_cnt + V_W'(1);
                    r_bar_px  <= '0;
                    r_bar_idx <= '0;
                end else begin
                    r_h_cnt <= r_h_cnt + H_W'(1);
                    if (r_bar_px == BAR_CW'(BAR_W - 1)) begin
                        r_bar_px  <= '0;
                        r_bar_idx <= r_bar_idx + 3'd1;
                    end else begin
                        r_bar_px <= r_bar_px + BAR_CW'(1);
                    end
                end
            end
        end
    end

    assign w_h      = int'(r_h_cnt);
    assign w_v      = int'(r_v_cnt);
    assign w_active = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    assign w_h_sync = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
    assign w_v_sync = (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC);
    assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_commit = w_pix_ce && w_origin;
    assign w_x      = 11'(r_h_cnt);
    assign w_y      = 10'(r_v_cnt);

    for (genvar k = 0; k < 3; k++) begin : g_key
        vga_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .i_clk   (CLOCK_50M),
            .i_reset (reset),
            .i_key_n (KEY[k]),
            .o_press (w_req[k])
        );
    end

    // NOTE: the origin pixel already reads the pending settings, so pixel (0,0) shows the
    // mode that commits on that same edge and a frame never mixes two patterns.
    assign w_mode_eff = (w_origin && r_pend[0]) ? mode_t'(r_mode + 2'd1) : r_mode;
    assign w_idx_eff  = (w_origin && r_pend[1]) ? r_idx + 3'd1 : r_idx;
    assign w_inv_eff  = (w_origin && r_pend[2]) ? ~r_inv : r_inv;

    always_ff @(posedge CLOCK_50M) begin
        if (reset) begin
            r_mode <= MODE_BARS;
            r_idx  <= '0;
            r_inv  <= 1'b0;
            r_pend <= '0;
        end else if (w_commit) begin
            r_mode <= w_mode_eff;
            r_idx  <= w_idx_eff;
            r_inv  <= w_inv_eff;
            r_pend <= w_req;
        end else begin
            r_pend <= r_pend | w_req;
        end
    end

    assign w_bar     = bar_colour(r_bar_idx);
    assign w_solid   = rgb1_t'(w_idx_eff);
    assign w_grid_on = (w_x[4:0] == 5'd0) || (w_y[4:0] == 5'd0);

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a colour unassigned.
        w_r = '0;
        w_g = '0;
        w_b = '0;
        unique case (w_mode_eff)
            MODE_BARS: begin
                w_r = {COLOR_W{w_bar.r}};
                w_g = {COLOR_W{w_bar.g}};
                w_b = {COLOR_W{w_bar.b}};
            end
            MODE_GRID: begin
                w_r = {COLOR_W{w_grid_on}};
                w_g = {COLOR_W{w_grid_on}};
                w_b = {COLOR_W{w_grid_on}};
            end
            MODE_GRAD: begin
                w_r = COLOR_W'(w_x);
                w_g = COLOR_W'(w_y);
            end
            MODE_SOLID: begin
                w_r = {COLOR_W{w_solid.r}};
                w_g = {COLOR_W{w_solid.g}};
                w_b = {COLOR_W{w_solid.b}};
            end
            default: ;
        endcase
        if (w_inv_eff) begin
            w_r = ~w_r;
            w_g = ~w_g;
            w_b = ~w_b;
        end
    end

    always_ff @(posedge CLOCK_50M) begin
        if (reset) begin
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_blank       <= 1'b0;
            r_r           <= '0;
            r_g           <= '0;
            r_b           <= '0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_commit;
            if (w_pix_ce) begin
                r_hs    <= w_h_sync ? HS_POL : ~HS_POL;
                r_vs    <= w_v_sync ? VS_POL : ~VS_POL;
                r_blank <= w_active;
                r_r     <= w_active ? w_r : '0;
                r_g     <= w_active ? w_g : '0;
                r_b     <= w_active ? w_b : '0;
                r_pix_x <= w_x;
                r_pix_y <= w_y;
            end
        end
    end

    assign hs          = r_hs;
    assign vs          = r_vs;
    assign VGA_BLANK   = r_blank;
    assign VGA_CLK     = r_vga_clk;
    assign VGA_R       = r_r;
    assign VGA_G       = r_g;
    assign VGA_B       = r_b;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign frame_start = r_frame_start;

endmodule
